// File: rtl/seven_segment_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_segment_scan_decoder
// Description : Recovers BCD digits from a multiplexed active-low 7-seg bus
//               and publishes complete frames with a one-cycle strobe.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_segment_scan_decoder #(
    parameter int NDIG          = 4,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic                ca,
    input  logic                cb,
    input  logic                cc,
    input  logic                cd,
    input  logic                ce,
    input  logic                cf,
    input  logic                cg,
    input  logic [NDIG-1:0]     an,
    output logic [4*NDIG-1:0]   digits,
    output logic                frame_valid,
    output logic                frame_err,
    output logic [NDIG-1:0]     seen
);

    localparam int c_sample_w = NDIG + 7;
    localparam int c_cnt_w    = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_cnt_w-1:0] c_stable = c_cnt_w'(STABLE_CYCLES);
    localparam logic [c_cnt_w-1:0] c_one    = c_cnt_w'(1);

    typedef enum logic [1:0] {
        S_WAIT  = 2'd0,
        S_COUNT = 2'd1,
        S_HELD  = 2'd2
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [c_cnt_w-1:0]     r_cnt, w_cnt_nxt, w_cnt_inc;
    logic [c_sample_w-1:0]  r_smp, r_prv;
    logic [4*NDIG-1:0]      r_stage, r_digits;
    logic [NDIG-1:0]        r_seen;
    logic                   r_err_acc, r_frame_valid, r_frame_err;

    logic [NDIG-1:0]        w_an, w_sel;
    logic [6:0]             w_seg;
    logic                   w_legal, w_same, w_restart, w_capture, w_publish;
    logic [3:0]             w_code;

    assign w_an      = r_smp[c_sample_w-1 -: NDIG];
    assign w_seg     = r_smp[6:0];
    assign w_sel     = ~w_an;
    assign w_legal   = $onehot(w_sel);
    assign w_same    = (r_smp == r_prv);
    assign w_publish = &r_seen;
    assign w_cnt_inc = (r_cnt >= c_stable) ? c_stable : r_cnt + c_one;

    always_comb begin
        w_code = 4'hE;
        case (w_seg)
            7'b0000001: w_code = 4'h0;
            7'b1001111: w_code = 4'h1;
            7'b0010010: w_code = 4'h2;
            7'b0000110: w_code = 4'h3;
            7'b1001100: w_code = 4'h4;
            7'b0100100: w_code = 4'h5;
            7'b0100000: w_code = 4'h6;
            7'b0001111: w_code = 4'h7;
            7'b0000000: w_code = 4'h8;
            7'b0000100: w_code = 4'h9;
            7'b1111111: w_code = 4'hF;
            default:    w_code = 4'hE;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_capture   = 1'b0;
        w_restart   = 1'b0;
        case (r_state)
            S_WAIT:  w_restart = 1'b1;
            S_COUNT: begin
                if (!w_same) begin
                    w_restart = 1'b1;
                end else begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == c_stable) begin
                        w_capture   = 1'b1;
                        w_state_nxt = S_HELD;
                    end
                end
            end
            S_HELD:  w_restart = !w_same;
            default: w_restart = 1'b1;
        endcase
        // A changed sample starts a fresh stability run; a one-cycle run captures at once
        if (w_restart) begin
            if (w_legal) begin
                w_cnt_nxt = c_one;
                if (c_stable == c_one) begin
                    w_capture   = 1'b1;
                    w_state_nxt = S_HELD;
                end else begin
                    w_state_nxt = S_COUNT;
                end
            end else begin
                w_cnt_nxt   = '0;
                w_state_nxt = S_WAIT;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_smp <= '1;
            r_prv <= '1;
        end else begin
            r_prv <= r_smp;
            r_smp <= {an, ca, cb, cc, cd, ce, cf, cg};
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            r_stage       <= '0;
            r_seen        <= '0;
            r_err_acc     <= 1'b0;
            r_digits      <= '0;
            r_frame_valid <= 1'b0;
            r_frame_err   <= 1'b0;
        end else begin
            if (w_capture) begin
                for (int i = 0; i < NDIG; i++) begin
                    if (w_sel[i]) r_stage[4*i +: 4] <= w_code;
                end
            end
            // On the publish edge a simultaneous capture seeds the next frame
            if (w_publish) begin
                r_digits      <= r_stage;
                r_frame_err   <= r_err_acc;
                r_frame_valid <= 1'b1;
                r_seen        <= w_capture ? w_sel : '0;
                r_err_acc     <= w_capture && (w_code == 4'hE);
            end else begin
                r_frame_valid <= 1'b0;
                if (w_capture) begin
                    r_seen    <= r_seen | w_sel;
                    r_err_acc <= r_err_acc | (w_code == 4'hE);
                end
            end
        end
    end

    assign digits      = r_digits;
    assign frame_valid = r_frame_valid;
    assign frame_err   = r_frame_err;
    assign seen        = r_seen;

endmodule
`default_nettype wire

// File: tb/tb_seven_segment_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_segment_scan_decoder
// Description : Scoreboard bench: hold-level reference model feeds expected
//               frames to a queue that a frame_valid monitor drains.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_segment_scan_decoder;

    localparam int NDIG   = 4;
    localparam int STABLE = 4;

    logic              clk = 1'b0;
    logic              resetn = 1'b1;
    logic              ca = 1'b1, cb = 1'b1, cc = 1'b1, cd = 1'b1;
    logic              ce = 1'b1, cf = 1'b1, cg = 1'b1;
    logic [NDIG-1:0]   an = '1;
    logic [4*NDIG-1:0] digits;
    logic              frame_valid, frame_err;
    logic [NDIG-1:0]   seen;

    seven_segment_scan_decoder #(.NDIG(NDIG), .STABLE_CYCLES(STABLE)) dut (
        .clk(clk), .resetn(resetn),
        .ca(ca), .cb(cb), .cc(cc), .cd(cd), .ce(ce), .cf(cf), .cg(cg),
        .an(an), .digits(digits), .frame_valid(frame_valid),
        .frame_err(frame_err), .seen(seen)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    logic [15:0] q_dig[$];
    logic        q_err[$];

    logic [3:0]      m_stage[NDIG];
    logic [NDIG-1:0] m_seen     = '0;
    logic            m_err      = 1'b0;
    logic [15:0]     m_last_dig = '0;
    logic            m_last_err = 1'b0;
    logic [10:0]     last_drv   = '1;

    logic [6:0] pat[10] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                            7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                            7'b0000000, 7'b0000100};

    function automatic logic [3:0] ref_decode(input logic [6:0] s);
        for (int k = 0; k < 10; k++) if (pat[k] == s) return 4'(k);
        if (s == 7'h7F) return 4'hF;
        return 4'hE;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errs++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [3:0] a, input logic [6:0] s);
        @(negedge clk);
        an = a;
        {ca, cb, cc, cd, ce, cf, cg} = s;
    endtask

    // One contiguous run of an identical bus value, then an optional idle gap
    task automatic hold(input logic [3:0] a, input logic [6:0] s, input int n, input int gap);
        logic [3:0] code;
        if ({a, s} == last_drv) s[0] = ~s[0];
        repeat (n) drive(a, s);
        last_drv = {a, s};
        if ($onehot(~a) && n >= STABLE) begin
            code = ref_decode(s);
            for (int i = 0; i < NDIG; i++) begin
                if (!a[i]) begin
                    m_stage[i] = code;
                    m_seen[i]  = 1'b1;
                end
            end
            m_err = m_err | (code == 4'hE);
            if (&m_seen) begin
                m_last_dig = {m_stage[3], m_stage[2], m_stage[1], m_stage[0]};
                m_last_err = m_err;
                q_dig.push_back(m_last_dig);
                q_err.push_back(m_last_err);
                m_seen = '0;
                m_err  = 1'b0;
            end
        end
        repeat (gap) drive(4'hF, 7'h7F);
        if (gap > 0) last_drv = {4'hF, 7'h7F};
        if (gap >= 2) begin
            @(negedge clk);
            check("seen", 32'(seen), 32'(m_seen));
            check("digits_held", 32'(digits), 32'(m_last_dig));
            check("frame_err_held", 32'(frame_err), 32'(m_last_err));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        resetn = 1'b0;
        an = '1;
        {ca, cb, cc, cd, ce, cf, cg} = 7'h7F;
        @(negedge clk);
        check("rst_digits", 32'(digits), 32'h0);
        check("rst_valid", 32'(frame_valid), 32'h0);
        check("rst_err", 32'(frame_err), 32'h0);
        check("rst_seen", 32'(seen), 32'h0);
        resetn = 1'b1;
        m_seen = '0; m_err = 1'b0; m_last_dig = '0; m_last_err = 1'b0;
        last_drv = {4'hF, 7'h7F};
    endtask

    function automatic logic [3:0] sel(input int slot);
        return ~(4'(1) << slot);
    endfunction

    always @(negedge clk) begin
        if (resetn && frame_valid === 1'b1) begin
            if (q_dig.size() == 0) begin
                n_checks++;
                n_errs++;
                $display("FAIL unexpected_frame: got digits %0h with nothing expected", digits);
            end else begin
                check("frame_digits", 32'(digits), 32'(q_dig.pop_front()));
                check("frame_err", 32'(frame_err), 32'(q_err.pop_front()));
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, got no end expected finish");
        $fatal(1);
    end

    initial begin
        logic [3:0] a;
        logic [6:0] s;
        int         slot, r;

        do_reset();

        // frame 2,0,2,4
        hold(sel(3), 7'b0010010, 6, 0);
        hold(sel(2), 7'b0000001, 6, 0);
        hold(sel(1), 7'b0010010, 6, 0);
        hold(sel(0), 7'b1001100, 6, 2);
        check("t1_digits", 32'(digits), 32'h2024);
        check("t1_err", 32'(frame_err), 32'h0);

        // short 8 on slot 0 must not be captured before the 1
        hold(sel(3), 7'b0100100, 6, 0);
        hold(sel(2), 7'b0000001, 6, 0);
        hold(sel(1), 7'b0001111, 6, 0);
        hold(sel(0), 7'b0000000, 3, 0);
        hold(sel(0), 7'b1001111, 6, 2);
        check("t2_digits", 32'(digits), 32'h5071);

        // undecodable slot 1, then a clean frame
        hold(sel(3), 7'b0000110, 6, 0);
        hold(sel(2), 7'b0100000, 6, 0);
        hold(sel(1), 7'b1110000, 6, 0);
        hold(sel(0), 7'b0000100, 6, 2);
        check("t3_digits", 32'(digits), 32'h36E9);
        check("t3_err", 32'(frame_err), 32'h1);
        hold(sel(3), 7'b0000001, 5, 0);
        hold(sel(2), 7'b1001111, 5, 0);
        hold(sel(1), 7'b0010010, 5, 0);
        hold(sel(0), 7'b0000110, 5, 2);
        check("t3_clean_err", 32'(frame_err), 32'h0);

        // blank slot 2
        hold(sel(3), 7'b1001100, 4, 0);
        hold(sel(2), 7'b1111111, 4, 0);
        hold(sel(1), 7'b0100100, 4, 0);
        hold(sel(0), 7'b0100000, 4, 2);
        check("t4_digits", 32'(digits), 32'h4F56);
        check("t4_err", 32'(frame_err), 32'h0);

        // illegal anodes never capture
        hold(sel(3), 7'b0001111, 6, 2);
        hold(4'b1111, 7'b0000001, 20, 2);
        hold(4'b0011, 7'b0010010, 20, 2);
        check("t5_seen", 32'(seen), 32'h8);
        hold(sel(2), 7'b0000000, 6, 0);
        hold(sel(1), 7'b0000100, 6, 0);
        hold(sel(0), 7'b0000001, 6, 2);

        // reset mid-frame discards the partial frame
        hold(sel(3), 7'b1001111, 6, 0);
        hold(sel(2), 7'b0010010, 6, 2);
        do_reset();
        hold(sel(1), 7'b0000110, 6, 0);
        hold(sel(0), 7'b1001100, 6, 2);
        repeat (5) drive(4'hF, 7'h7F);
        check("t6_seen", 32'(seen), 32'h3);
        check("t6_digits", 32'(digits), 32'h0);
        hold(sel(3), 7'b0100100, 6, 0);
        hold(sel(2), 7'b0100000, 6, 2);
        check("t6_digits_after", 32'(digits), 32'h5634);

        // recapture overwrites slot 3
        hold(sel(3), 7'b0100100, 6, 2);
        hold(sel(3), 7'b0000100, 6, 0);
        hold(sel(2), 7'b0001111, 6, 0);
        hold(sel(1), 7'b0000000, 6, 0);
        hold(sel(0), 7'b0000001, 6, 2);
        check("t7_digits", 32'(digits), 32'h9780);

        // randomized runs
        for (int n = 0; n < 200; n++) begin
            slot = int'($urandom_range(0, NDIG - 1));
            r = int'($urandom_range(0, 99));
            if (r < 85)      a = sel(slot);
            else if (r < 92) a = 4'hF;
            else             a = sel(slot) & sel((slot + 1) % NDIG);
            r = int'($urandom_range(0, 99));
            if (r < 60)      s = pat[$urandom_range(0, 9)];
            else if (r < 70) s = 7'h7F;
            else             s = 7'($urandom);
            hold(a, s, int'($urandom_range(1, 7)), int'($urandom_range(0, 2)));
        end

        repeat (10) drive(4'hF, 7'h7F);
        check("pending_frames", 32'(q_dig.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
